// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one memory controller; one transaction outstanding at a time.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-breaking; default build is fixed priority (p1 wins ties).
module mem_arbiter #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) (
  input  logic          mclk,
  input  logic          reset,
  input  logic          p0_req,
  input  logic          p0_rw,
  input  logic [1:0]    p0_size,
  input  logic [AW-1:0] p0_address,
  input  logic [DW-1:0] p0_write_data,
  output logic [DW-1:0] p0_read_data,
  output logic          p0_data_valid,
  input  logic          p1_req,
  input  logic          p1_rw,
  input  logic [1:0]    p1_size,
  input  logic [AW-1:0] p1_address,
  input  logic [DW-1:0] p1_write_data,
  output logic [DW-1:0] p1_read_data,
  output logic          p1_data_valid,
  output logic          m_rw_req,
  output logic          m_rw,
  output logic [1:0]    m_size,
  output logic [AW-1:0] m_address,
  output logic [DW-1:0] m_write_data,
  input  logic [DW-1:0] m_read_data,
  input  logic          m_data_valid,
  output logic [1:0]    grant
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t state;
  logic   last_served;  // 1 = p1 served most recently
  logic   pick_p1_c;
  logic   granted_req_c;

  // Winner selection among ports requesting in IDLE
  always_comb begin
    pick_p1_c = p1_req;
`ifdef ARB_ROUND_ROBIN_EN
    if (p0_req && p1_req) begin
      pick_p1_c = ~last_served;
    end
`else
    pick_p1_c = p1_req;
`endif
  end

  assign granted_req_c = grant[1] ? p1_req : p0_req;

  always_ff @(posedge mclk) begin
    if (!reset) begin
      state         <= IDLE;
      last_served   <= 1'b1;
      grant         <= 2'b00;
      m_rw_req      <= 1'b0;
      m_rw          <= 1'b0;
      m_size        <= 2'b00;
      m_address     <= '0;
      m_write_data  <= '0;
      p0_read_data  <= '0;
      p1_read_data  <= '0;
      p0_data_valid <= 1'b0;
      p1_data_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (p0_req || p1_req) begin
            m_rw_req <= 1'b1;
            state    <= BUSY;
            if (pick_p1_c) begin
              grant        <= 2'b10;
              m_rw         <= p1_rw;
              m_size       <= p1_size;
              m_address    <= p1_address;
              m_write_data <= p1_write_data;
            end else begin
              grant        <= 2'b01;
              m_rw         <= p0_rw;
              m_size       <= p0_size;
              m_address    <= p0_address;
              m_write_data <= p0_write_data;
            end
          end
        end
        BUSY: begin
          // Read data is returned for writes too; requester ignores it
          if (m_data_valid) begin
            m_rw_req <= 1'b0;
            state    <= RELEASE;
            if (grant[1]) begin
              p1_read_data  <= m_read_data;
              p1_data_valid <= 1'b1;
            end else begin
              p0_read_data  <= m_read_data;
              p0_data_valid <= 1'b1;
            end
          end
        end
        RELEASE: begin
          if (!granted_req_c && !m_data_valid) begin
            p0_data_valid <= 1'b0;
            p1_data_valid <= 1'b0;
            grant         <= 2'b00;
            last_served   <= grant[1];
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
